// File: rtl/isa_pkg.sv
// Shared ISA constants for the 19-bit instruction format, used by both the encoder/loader and the decoder.
package isa_pkg;

    localparam int INSTR_W  = 19;
    localparam int OPCODE_W = 5;
    localparam int REG_W    = 4;
    localparam int IMM_W    = 10;
    localparam int JADDR_W  = 14;

    localparam int OP_LSB   = 14;
    localparam int RD_LSB   = 10;
    localparam int RS1_LSB  = 6;
    localparam int RS2_LSB  = 2;
    localparam int IMM_LSB  = 0;
    localparam int JADDR_LSB = 0;

    typedef enum logic [1:0] {
        FMT_R   = 2'd0,
        FMT_I   = 2'd1,
        FMT_J   = 2'd2,
        FMT_BAD = 2'd3
    } fmt_e;

endpackage

// File: rtl/instr_encoder.sv
// Pure combinational field packer: format + fields -> 19-bit instruction word, plus an illegal-format flag.
module instr_encoder
    import isa_pkg::*;
(
    input  fmt_e                i_fmt,
    input  logic [OPCODE_W-1:0] i_opcode,
    input  logic [REG_W-1:0]    i_rd,
    input  logic [REG_W-1:0]    i_rs1,
    input  logic [REG_W-1:0]    i_rs2,
    input  logic [IMM_W-1:0]    i_imm,
    input  logic [JADDR_W-1:0]  i_addr,
    output logic [INSTR_W-1:0]  o_word,
    output logic                o_illegal
);

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
        o_word    = '0;
        o_illegal = 1'b0;
        o_word[OP_LSB +: OPCODE_W] = i_opcode;
        case (i_fmt)
            FMT_R: begin
                o_word[RD_LSB  +: REG_W] = i_rd;
                o_word[RS1_LSB +: REG_W] = i_rs1;
                o_word[RS2_LSB +: REG_W] = i_rs2;
            end
            FMT_I: begin
                o_word[RD_LSB  +: REG_W] = i_rd;
                o_word[IMM_LSB +: IMM_W] = i_imm;
            end
            FMT_J: begin
                o_word[JADDR_LSB +: JADDR_W] = i_addr;
            end
            default: begin
                o_word    = '0;
                o_illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// Session-based loader: accepts a valid/ready stream of instruction fields, encodes them and writes
// consecutive imem words from a base address, flagging overflow and illegal formats.
module instr_encoder_loader
    import isa_pkg::*;
#(
    parameter int PC_W  = 8,
    parameter int DEPTH = 256
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [PC_W-1:0]     base_addr,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [1:0]          in_fmt,
    input  logic [OPCODE_W-1:0] in_opcode,
    input  logic [REG_W-1:0]    in_rd,
    input  logic [REG_W-1:0]    in_rs1,
    input  logic [REG_W-1:0]    in_rs2,
    input  logic [IMM_W-1:0]    in_imm,
    input  logic [JADDR_W-1:0]  in_addr,
    input  logic                in_last,
    output logic                mem_we,
    output logic [PC_W-1:0]     mem_addr,
    output logic [INSTR_W-1:0]  mem_wdata,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [PC_W:0]       count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2,
        S_ERR  = 2'd3
    } state_e;

    localparam logic [PC_W-1:0] LAST_ADDR = PC_W'(DEPTH - 1);

    state_e               r_state;
    logic [PC_W-1:0]      r_ptr;
    logic [PC_W:0]        r_count;
    logic                 r_mem_we;
    logic [PC_W-1:0]      r_mem_addr;
    logic [INSTR_W-1:0]   r_mem_wdata;
    logic                 r_done;
    logic                 r_err;

    logic [INSTR_W-1:0]   w_word;
    logic                 w_illegal;
    logic                 w_accept;
    logic                 w_at_end;

    instr_encoder u_encoder (
        .i_fmt     (fmt_e'(in_fmt)),
        .i_opcode  (in_opcode),
        .i_rd      (in_rd),
        .i_rs1     (in_rs1),
        .i_rs2     (in_rs2),
        .i_imm     (in_imm),
        .i_addr    (in_addr),
        .o_word    (w_word),
        .o_illegal (w_illegal)
    );

    // start steals the cycle so a beat presented alongside it is not consumed.
    assign in_ready = (r_state == S_LOAD) && !start;
    assign w_accept = in_valid && in_ready;
    assign w_at_end = (r_ptr >= LAST_ADDR);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_ptr       <= '0;
            r_count     <= '0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_mem_we <= 1'b0;
            if (start) begin
                r_state <= S_LOAD;
                r_ptr   <= base_addr;
                r_count <= '0;
                r_done  <= 1'b0;
                r_err   <= 1'b0;
            end else if (w_accept) begin
                if (w_illegal) begin
                    r_err   <= 1'b1;
                    r_state <= S_ERR;
                end else begin
                    r_mem_we    <= 1'b1;
                    r_mem_addr  <= r_ptr;
                    r_mem_wdata <= w_word;
                    r_count     <= r_count + (PC_W+1)'(1);
                    // The pointer parks on the last word rather than wrapping back to 0.
                    if (!w_at_end) begin
                        r_ptr <= r_ptr + PC_W'(1);
                    end
                    if (in_last) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end else if (w_at_end) begin
                        r_state <= S_ERR;
                        r_err   <= 1'b1;
                    end
                end
            end
        end
    end

    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign busy      = (r_state == S_LOAD);
    assign done      = r_done;
    assign err       = r_err;
    assign count     = r_count;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader: a table of encoded beats streamed in one session, then
// hand-written sequences for overflow, illegal format, start-during-load and mid-session reset.
module tb_instr_encoder_loader;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  base_addr;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_fmt;
    logic [4:0]  in_opcode;
    logic [3:0]  in_rd;
    logic [3:0]  in_rs1;
    logic [3:0]  in_rs2;
    logic [9:0]  in_imm;
    logic [13:0] in_addr;
    logic        in_last;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [18:0] mem_wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [8:0]  count;

    int n_checks = 0;
    int n_fail   = 0;

    instr_encoder_loader #(.PC_W(8), .DEPTH(256)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_fmt    (in_fmt),
        .in_opcode (in_opcode),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_imm    (in_imm),
        .in_addr   (in_addr),
        .in_last   (in_last),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  fmt;
        logic [4:0]  op;
        logic [3:0]  rd;
        logic [3:0]  rs1;
        logic [3:0]  rs2;
        logic [9:0]  imm;
        logic [13:0] addr;
        logic        last;
        logic [18:0] exp;
    } vec_t;

    localparam int NVEC = 7;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_vec(input vec_t v);
        in_fmt    = v.fmt;
        in_opcode = v.op;
        in_rd     = v.rd;
        in_rs1    = v.rs1;
        in_rs2    = v.rs2;
        in_imm    = v.imm;
        in_addr   = v.addr;
        in_last   = v.last;
    endtask

    // Pulses start for one cycle; returns at the negedge after the start edge (state is LOAD).
    task automatic do_start(input logic [7:0] base);
        @(negedge clk);
        start     = 1'b1;
        base_addr = base;
        in_valid  = 1'b0;
        @(negedge clk);
        start     = 1'b0;
    endtask

    initial begin
        vecs[0] = '{2'd0, 5'h03, 4'h1, 4'h2, 4'h3, 10'h000, 14'h0000, 1'b0, 19'h0C48C};
        vecs[1] = '{2'd1, 5'h10, 4'h4, 4'h0, 4'h0, 10'h3FF, 14'h0000, 1'b0, 19'h413FF};
        vecs[2] = '{2'd2, 5'h1F, 4'h0, 4'h0, 4'h0, 10'h000, 14'h2AAA, 1'b0, 19'h7EAAA};
        vecs[3] = '{2'd0, 5'h1F, 4'hF, 4'hF, 4'hF, 10'h000, 14'h0000, 1'b0, 19'h7FFFC};
        vecs[4] = '{2'd0, 5'h05, 4'h2, 4'h0, 4'h1, 10'h3FF, 14'h3FFF, 1'b0, 19'h14804};
        vecs[5] = '{2'd1, 5'h00, 4'h0, 4'hF, 4'hF, 10'h155, 14'h3FFF, 1'b0, 19'h00155};
        vecs[6] = '{2'd2, 5'h01, 4'hF, 4'hF, 4'hF, 10'h3FF, 14'h0001, 1'b1, 19'h04001};

        rst_n = 1'b0; start = 1'b0; base_addr = '0; in_valid = 1'b0;
        drive_vec(vecs[0]);
        repeat (2) @(negedge clk);

        check("rst_mem_we",  32'(mem_we), 32'd0);
        check("rst_addr",    32'(mem_addr), 32'd0);
        check("rst_wdata",   32'(mem_wdata), 32'd0);
        check("rst_busy",    32'(busy), 32'd0);
        check("rst_done",    32'(done), 32'd0);
        check("rst_err",     32'(err), 32'd0);
        check("rst_count",   32'(count), 32'd0);
        check("rst_ready",   32'(in_ready), 32'd0);
        rst_n = 1'b1;

        // In IDLE a valid beat is ignored.
        in_valid = 1'b1;
        @(negedge clk);
        check("idle_ready", 32'(in_ready), 32'd0);
        check("idle_no_we", 32'(mem_we), 32'd0);

        // Table session from base 0x10, streaming one beat per cycle.
        do_start(8'h10);
        check("s1_busy",  32'(busy), 32'd1);
        check("s1_count0", 32'(count), 32'd0);
        for (int i = 0; i < NVEC; i++) begin
            drive_vec(vecs[i]);
            in_valid = 1'b1;
            #1;
            check($sformatf("s1_ready[%0d]", i), 32'(in_ready), 32'd1);
            @(negedge clk);
            check($sformatf("s1_we[%0d]", i),    32'(mem_we), 32'd1);
            check($sformatf("s1_addr[%0d]", i),  32'(mem_addr), 32'h10 + 32'(i));
            check($sformatf("s1_wdata[%0d]", i), 32'(mem_wdata), 32'(vecs[i].exp));
            check($sformatf("s1_count[%0d]", i), 32'(count), 32'(i + 1));
        end
        check("s1_done",  32'(done), 32'd1);
        check("s1_err",   32'(err), 32'd0);
        check("s1_busy_end", 32'(busy), 32'd0);
        check("s1_ready_end", 32'(in_ready), 32'd0);
        @(negedge clk);
        check("s1_we_drop", 32'(mem_we), 32'd0);
        check("s1_count_hold", 32'(count), 32'd7);
        in_valid = 1'b0;

        // Overflow: base 0xFE, three non-last beats offered.
        do_start(8'hFE);
        drive_vec(vecs[0]);
        in_valid = 1'b1;
        @(negedge clk);
        check("ovf_we1",   32'(mem_we), 32'd1);
        check("ovf_addr1", 32'(mem_addr), 32'hFE);
        check("ovf_err1",  32'(err), 32'd0);
        @(negedge clk);
        check("ovf_we2",   32'(mem_we), 32'd1);
        check("ovf_addr2", 32'(mem_addr), 32'hFF);
        check("ovf_err2",  32'(err), 32'd1);
        check("ovf_ready", 32'(in_ready), 32'd0);
        check("ovf_busy",  32'(busy), 32'd0);
        check("ovf_count", 32'(count), 32'd2);
        @(negedge clk);
        check("ovf_no_we3", 32'(mem_we), 32'd0);
        check("ovf_count3", 32'(count), 32'd2);
        check("ovf_done",   32'(done), 32'd0);
        in_valid = 1'b0;

        // Illegal format mid-stream, then a new start clears err.
        do_start(8'h40);
        check("ill_start_clr_err", 32'(err), 32'd0);
        drive_vec(vecs[2]);
        in_valid = 1'b1;
        @(negedge clk);
        check("ill_we1",    32'(mem_we), 32'd1);
        check("ill_addr1",  32'(mem_addr), 32'h40);
        in_fmt  = 2'd3;
        in_last = 1'b1;
        @(negedge clk);
        check("ill_no_we",  32'(mem_we), 32'd0);
        check("ill_err",    32'(err), 32'd1);
        check("ill_done",   32'(done), 32'd0);
        check("ill_count",  32'(count), 32'd1);
        check("ill_ready",  32'(in_ready), 32'd0);
        in_valid = 1'b0;
        do_start(8'h50);
        check("ill_err_clr", 32'(err), 32'd0);
        check("ill_busy",    32'(busy), 32'd1);
        drive_vec(vecs[0]);
        in_last  = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        check("ill_re_addr",  32'(mem_addr), 32'h50);
        check("ill_re_wdata", 32'(mem_wdata), 32'h0C48C);
        check("ill_re_done",  32'(done), 32'd1);
        check("ill_re_count", 32'(count), 32'd1);
        in_valid = 1'b0;

        // start during LOAD with a valid beat present: beat is held back, pointer moves to new base.
        do_start(8'h60);
        drive_vec(vecs[1]);
        in_valid = 1'b1;
        @(negedge clk);
        check("sl_we1",   32'(mem_we), 32'd1);
        check("sl_addr1", 32'(mem_addr), 32'h60);
        start     = 1'b1;
        base_addr = 8'h70;
        #1;
        check("sl_ready_start", 32'(in_ready), 32'd0);
        @(negedge clk);
        start = 1'b0;
        check("sl_no_we",  32'(mem_we), 32'd0);
        check("sl_count0", 32'(count), 32'd0);
        check("sl_busy",   32'(busy), 32'd1);
        @(negedge clk);
        check("sl_we2",    32'(mem_we), 32'd1);
        check("sl_addr2",  32'(mem_addr), 32'h70);
        check("sl_wdata2", 32'(mem_wdata), 32'h413FF);
        check("sl_count1", 32'(count), 32'd1);

        // Asynchronous reset while a write is being presented.
        @(posedge clk);
        #2;
        check("rs_we_before", 32'(mem_we), 32'd1);
        check("rs_addr_before", 32'(mem_addr), 32'h71);
        rst_n = 1'b0;
        #1;
        check("rs_we",    32'(mem_we), 32'd0);
        check("rs_addr",  32'(mem_addr), 32'd0);
        check("rs_wdata", 32'(mem_wdata), 32'd0);
        check("rs_count", 32'(count), 32'd0);
        check("rs_busy",  32'(busy), 32'd0);
        check("rs_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        check("rs_we_held", 32'(mem_we), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rs_idle_we",   32'(mem_we), 32'd0);
        check("rs_idle_busy", 32'(busy), 32'd0);
        check("rs_idle_count", 32'(count), 32'd0);
        in_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
